uart_periph: RTL

//  Memory-mapped UART peripheral on the MEM-stage data bus of the 5-stage MIPS pipeline.

---
 rtl/uart_periph_pkg.sv | 41 ++++
 rtl/uart_periph_if.sv | 14 +
 rtl/uart_periph_baud_gen.sv | 28 ++
 rtl/uart_periph.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_periph_pkg.sv
// Shared definitions for the UART peripheral: register offsets, CON bit
// positions, FSM state encodings and the word-address match helper.
package uart_periph_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] TXD_OFS = 32'd0;
    localparam logic [31:0] RXD_OFS = 32'd4;
    localparam logic [31:0] CON_OFS = 32'd8;

    // CON bit positions
    localparam int CON_TX_IE      = 0;
    localparam int CON_RX_IE      = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;

    // Ticks of the 16x oversample clock per bit, and the mid-bit start sample
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Word-granular address compare; byte offset bits are ignored
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/uart_periph_if.sv
// MEM-stage data bus as seen by a memory-mapped peripheral.
// Handshake: there is no valid/ready pair. mem_rd and mem_wr are single-cycle
// strobes that are always accepted in the cycle they are high; the peripheral
// never stalls. rdata is combinational and valid in the same cycle as mem_rd.
interface uart_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output mem_rd, output mem_wr, input rdata);
    modport slave  (input addr, input wdata, input mem_rd, input mem_wr, output rdata);
endinterface

// File: rtl/uart_periph_baud_gen.sv
// 16x oversample tick generator: one-cycle tick every DIV clocks.
// A synchronous clr restarts the count so a frame can align its bit timing.
module uart_periph_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter, wraps at DIV-1 or restarts on clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST) && !clr;
endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART on the MEM-stage bus: TXD/RXD/CON registers,
// transmit and receive FSMs, and a registered level interrupt.
module uart_periph
    import uart_periph_pkg::*;
#(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic          clk,
    input  logic          reset,
    uart_periph_if.slave  bus,
    input  logic          uart_rx,
    output logic          uart_tx,
    output logic          irq,
    output tx_state_t     tx_state_dbg,
    output rx_state_t     rx_state_dbg
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam logic [31:0] TXD_ADDR = BASE_ADDR + TXD_OFS;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + RXD_OFS;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + CON_OFS;

    // Address decode
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;
    assign sel_txd = word_match(bus.addr, TXD_ADDR);
    assign sel_rxd = word_match(bus.addr, RXD_ADDR);
    assign sel_con = word_match(bus.addr, CON_ADDR);
    assign wr_txd  = bus.mem_wr && sel_txd;
    assign wr_con  = bus.mem_wr && sel_con;
    assign rd_rxd  = bus.mem_rd && sel_rxd;
    assign rd_con  = bus.mem_rd && sel_con;

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

    // Register state
    logic [7:0] txd_q, rxd_q;
    logic       tx_ie, rx_ie, tx_done, rx_valid, tx_busy, rx_overrun;

    // TX state
    tx_state_t  tx_state;
    logic [3:0] tx_tick_cnt;
    logic [2:0] tx_bit_cnt;
    logic [7:0] tx_shift;
    logic       tx_tick, tx_start, tx_bit_end;

    // RX state
    rx_state_t  rx_state;
    logic [3:0] rx_tick_cnt;
    logic [2:0] rx_bit_cnt;
    logic [7:0] rx_shift;
    logic       rx_meta, rx_sync, rx_prev, rx_tick, rx_done;

    assign tx_start   = wr_txd && (tx_state == TX_IDLE);
    assign tx_bit_end = tx_tick && (tx_tick_cnt == TICK_LAST);
    assign rx_done    = (rx_state == RX_STOP) && rx_tick && (rx_tick_cnt == TICK_LAST) && rx_sync;

    uart_periph_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk(clk), .reset(reset), .clr(tx_start), .tick(tx_tick)
    );

    uart_periph_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk(clk), .reset(reset), .clr(1'b0), .tick(rx_tick)
    );

    // Combinational read mux; zero unless a read hits one of our registers
    always_comb begin
        bus.rdata = '0;
        if (bus.mem_rd) begin
            if (sel_txd) begin
                bus.rdata[7:0] = txd_q;
            end else if (sel_rxd) begin
                bus.rdata[7:0] = rxd_q;
            end else if (sel_con) begin
                bus.rdata[7:0] = {2'b00, rx_overrun, tx_busy, rx_valid, tx_done, rx_ie, tx_ie};
            end
        end
    end

    // Interrupt enables: the only writable CON bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie <= 1'b0;
            rx_ie <= 1'b0;
        end else if (wr_con) begin
            tx_ie <= bus.wdata[CON_TX_IE];
            rx_ie <= bus.wdata[CON_RX_IE];
        end
    end

    // TX FSM: start, 8 data bits LSB first, stop; each state 16 ticks long
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            uart_tx     <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            txd_q       <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (wr_txd) begin
                        txd_q       <= bus.wdata[7:0];
                        tx_shift    <= bus.wdata[7:0];
                        uart_tx     <= 1'b0;
                        tx_busy     <= 1'b1;
                        tx_tick_cnt <= '0;
                        tx_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        uart_tx     <= tx_shift[0];
                        tx_bit_cnt  <= '0;
                        tx_tick_cnt <= '0;
                        tx_state    <= TX_DATA;
                    end else if (tx_tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_tick_cnt <= '0;
                        if (tx_bit_cnt == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_tx    <= tx_shift[1];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            tx_bit_cnt <= tx_bit_cnt + 3'd1;
                        end
                    end else if (tx_tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_busy     <= 1'b0;
                        tx_tick_cnt <= '0;
                        tx_state    <= TX_IDLE;
                    end else if (tx_tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase

            // Completion sets the sticky flag and beats a same-cycle CON read
            if (tx_state == TX_STOP && tx_bit_end) begin
                tx_done <= 1'b1;
            end else if (rd_con) begin
                tx_done <= 1'b0;
            end
        end
    end

    // RX FSM: synchronise, detect start edge, sample mid-bit, capture on good stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rxd_q       <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_tick_cnt <= '0;
                        rx_state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == TICK_MID) begin
                            rx_tick_cnt <= '0;
                            rx_bit_cnt  <= '0;
                            rx_state    <= rx_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == TICK_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_shift    <= {rx_sync, rx_shift[7:1]};
                            if (rx_bit_cnt == 3'd7) begin
                                rx_state <= RX_STOP;
                            end else begin
                                rx_bit_cnt <= rx_bit_cnt + 3'd1;
                            end
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == TICK_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_state    <= RX_IDLE;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase

            if (rx_done) begin
                rxd_q <= rx_shift;
            end

            // Receive beats a same-cycle RXD read
            if (rx_done) begin
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end

            // Overrun when a new byte lands on an unread one; beats a CON read
            if (rx_done && rx_valid) begin
                rx_overrun <= 1'b1;
            end else if (rd_con) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // Registered interrupt request, one cycle behind the flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (tx_ie && tx_done) || (rx_ie && rx_valid);
        end
    end

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;
endmodule
